// File: rtl/xdma_sched_pkg.sv
// xdma_sched_pkg: shared state type and index-width helper for the stream scheduler
package xdma_sched_pkg;

    typedef enum logic {IDLE, BUSY} state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xdma_rr_select.sv
// xdma_rr_select: combinational round-robin pick of the first request at or after ptr_i
module xdma_rr_select
    import xdma_sched_pkg::*;
#(
    parameter int N_INP = 2,
    localparam int IDX_W = idx_w(N_INP)
) (
    input  logic [N_INP-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // scan from the far end back toward ptr_i so the closest request overwrites last
    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        for (int i = N_INP - 1; i >= 0; i--) begin
            if (req_i[(int'(ptr_i) + i) % N_INP]) idx_o = IDX_W'((int'(ptr_i) + i) % N_INP);
        end
    end

endmodule

// File: rtl/xdma_stream_scheduler.sv
// xdma_stream_scheduler: round-robin burst arbiter forwarding one requester's stream at a time
module xdma_stream_scheduler
    import xdma_sched_pkg::*;
#(
    parameter type data_t = logic,
    parameter int  N_INP  = 2,
    parameter int  LEN_W  = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  data_t [N_INP-1:0]            inp_data_i,
    input  logic  [N_INP-1:0]            inp_valid_i,
    input  logic  [N_INP-1:0][LEN_W-1:0] inp_len_i,
    output logic  [N_INP-1:0]            inp_ready_o,
    output data_t                        oup_data_o,
    output logic                         oup_valid_o,
    output logic                         oup_last_o,
    input  logic                         oup_ready_i,
    output logic  [N_INP-1:0]            grant_o,
    output logic                         start_o,
    output logic                         done_o,
    output logic                         busy_o
);

    localparam int IDX_W = idx_w(N_INP);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_valid;
    logic               busy, own_valid, last, hs;

    xdma_rr_select #(.N_INP(N_INP)) u_rr_select (
        .req_i   (inp_valid_i),
        .ptr_i   (rr_ptr_q),
        .idx_o   (sel_idx),
        .valid_o (sel_valid)
    );

    // arbitration in IDLE, beat counting in BUSY; counter restarts at each grant so a full-range burst never wraps
    always_comb begin
        busy       = state_q == BUSY;
        own_valid  = busy && inp_valid_i[idx_q];
        last       = beat_cnt_q == len_q;
        hs         = own_valid && oup_ready_i;
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        idx_d      = idx_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        if (!busy && sel_valid) begin
            state_d    = BUSY;
            idx_d      = sel_idx;
            len_d      = inp_len_i[sel_idx];
            beat_cnt_d = '0;
        end else if (hs && last) begin
            state_d    = IDLE;
            rr_ptr_d   = (idx_q == IDX_W'(N_INP - 1)) ? '0 : idx_q + 1'b1;
            beat_cnt_d = '0;
        end else if (hs) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
    end

    // outputs are forced low while reset is held so an aborted burst never leaks a beat or done
    always_comb begin
        inp_ready_o = '0;
        grant_o     = '0;
        if (rst_ni && busy) begin
            inp_ready_o[idx_q] = oup_ready_i;
            grant_o[idx_q]     = 1'b1;
        end
        oup_data_o  = (rst_ni && busy) ? inp_data_i[idx_q] : '0;
        oup_valid_o = rst_ni && own_valid;
        oup_last_o  = rst_ni && own_valid && last;
        start_o     = rst_ni && !busy && sel_valid;
        done_o      = rst_ni && hs && last;
        busy_o      = rst_ni && busy;
    end

    // all scheduler state
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule
